// File: rtl/mc_port_responder.sv
// rtl/mc_port_responder.sv - fixed-latency memory port responder with in-order response FIFO and flush tracking
// Optional feature macro: MC_PORT_RESP_RAND_LAT_EN (LFSR-driven 0..7 extra hold cycles at the FIFO head).
module mc_port_responder #(
  parameter int RTNCTL_WIDTH = 32,
  parameter int ADDR_W       = 10,
  parameter int LATENCY      = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mc_rq_vld,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [1:0]              mc_rq_size,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]             mc_rq_data,
  input  logic                    mc_rq_flush,
  output logic                    mc_rq_stall,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  output logic                    mc_rs_flush_cmplt,
  output logic                    err_unsup,
  output logic                    err_ovf
);
  localparam int DL = LATENCY - 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = 1 + 4 + RTNCTL_WIDTH + 64;

  logic [63:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              is_rd, is_wr, full, kept;
  logic [OW-1:0]     occ, occ_next;
  logic [EW-1:0]     new_ent, out_ent, tail_ent;
  logic [DL-1:0]     dl_vld;
  logic [EW-1:0]     dl_ent [DL];
  logic [EW-1:0]     fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     fifo_cnt;
  logic              tail_vld, fifo_ne, hold_ok, issue, bypass, push, pop;
  logic              pend, pend_c;
  logic [OW-1:0]     pend_cnt, cnt_c;
  logic              unused_bits;

  assign unused_bits = ^{mc_rq_size, mc_rq_vadr[47:ADDR_W+3], mc_rq_vadr[2:0]};

  assign idx     = mc_rq_vadr[ADDR_W+2:3];
  assign is_rd   = mc_rq_vld && (mc_rq_cmd == 3'd1);
  assign is_wr   = mc_rq_vld && (mc_rq_cmd == 3'd2);
  assign full    = (occ == OW'(FIFO_DEPTH));
  assign kept    = (is_rd || is_wr) && !full;
  // entry layout: {is_write, scmd, rtnctl, data}
  assign new_ent = {is_wr, mc_rq_scmd, mc_rq_rtnctl, is_wr ? 64'd0 : mem[idx]};

  always_ff @(posedge clk) begin
    if (is_wr) mem[idx] <= mc_rq_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= kept;
      for (int k = 1; k < DL; k++) dl_vld[k] <= dl_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_ent[0] <= new_ent;
    for (int k = 1; k < DL; k++) dl_ent[k] <= dl_ent[k-1];
  end

  // The output register is the final delay stage; an empty FIFO lets the tail bypass straight into it.
  assign tail_vld = dl_vld[DL-1];
  assign tail_ent = dl_ent[DL-1];
  assign fifo_ne  = (fifo_cnt != '0);
  assign issue    = !mc_rs_stall && hold_ok && (fifo_ne || tail_vld);
  assign bypass   = issue && !fifo_ne;
  assign pop      = issue && fifo_ne;
  assign push     = tail_vld && !bypass;
  assign out_ent  = fifo_ne ? fifo[rd_ptr] : tail_ent;
  assign occ_next = occ + OW'(kept) - OW'(issue);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= tail_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      occ         <= '0;
      mc_rq_stall <= 1'b0;
      err_unsup   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt    <= fifo_cnt + OW'(push) - OW'(pop);
      occ         <= occ_next;
      mc_rq_stall <= (occ_next >= OW'(FIFO_DEPTH - 2));
      if (mc_rq_vld && !is_rd && !is_wr) err_unsup <= 1'b1;
      if ((is_rd || is_wr) && full)      err_ovf   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_rs_vld    <= 1'b0;
      mc_rs_cmd    <= '0;
      mc_rs_scmd   <= '0;
      mc_rs_rtnctl <= '0;
      mc_rs_data   <= '0;
    end else begin
      mc_rs_vld <= issue;
      if (issue) begin
        mc_rs_cmd    <= out_ent[EW-1] ? 3'd3 : 3'd2;
        mc_rs_scmd   <= out_ent[EW-2 -: 4];
        mc_rs_rtnctl <= out_ent[64 +: RTNCTL_WIDTH];
        mc_rs_data   <= out_ent[63:0];
      end
    end
  end

  // A flush owns every response still in flight at its arrival; the oldest leave first, so a count suffices.
  always_comb begin
    pend_c = pend || mc_rq_flush;
    cnt_c  = mc_rq_flush ? occ + OW'(kept) : pend_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend              <= 1'b0;
      pend_cnt          <= '0;
      mc_rs_flush_cmplt <= 1'b0;
    end else begin
      mc_rs_flush_cmplt <= pend_c && (cnt_c == '0);
      pend              <= pend_c && (cnt_c != '0);
      pend_cnt          <= cnt_c - OW'(issue && (cnt_c != '0));
    end
  end

`ifdef MC_PORT_RESP_RAND_LAT_EN
  logic [15:0] lfsr;
  logic [2:0]  hold;

  assign hold_ok = (hold == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
      hold <= 3'd0;
    end else if (issue) begin
      hold <= lfsr[2:0];
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end else if ((hold != 3'd0) && (fifo_ne || tail_vld)) begin
      hold <= hold - 3'd1;
    end
  end
`else
  assign hold_ok = 1'b1;
`endif

endmodule

// File: tb/tb_mc_port_responder.sv
// tb/tb_mc_port_responder.sv - randomized self-checking bench for mc_port_responder
// Reference model: response queue with ready times, sequence-number flush targets, word-indexed store.
module tb_mc_port_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rq_vld = 1'b0;
  logic [2:0]  rq_cmd = '0;
  logic [3:0]  rq_scmd = '0;
  logic [47:0] rq_vadr = '0;
  logic [1:0]  rq_size = '0;
  logic [31:0] rq_rtnctl = '0;
  logic [63:0] rq_data = '0;
  logic        rq_flush = 1'b0;
  logic        rs_stall = 1'b0;
  logic        rq_stall, rs_vld, flush_cmplt, err_unsup, err_ovf;
  logic [2:0]  rs_cmd;
  logic [3:0]  rs_scmd;
  logic [63:0] rs_data;
  logic [31:0] rs_rtnctl;

  mc_port_responder #(.RTNCTL_WIDTH(32), .ADDR_W(10), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mc_rq_vld(rq_vld), .mc_rq_cmd(rq_cmd), .mc_rq_scmd(rq_scmd),
    .mc_rq_vadr(rq_vadr), .mc_rq_size(rq_size), .mc_rq_rtnctl(rq_rtnctl), .mc_rq_data(rq_data),
    .mc_rq_flush(rq_flush), .mc_rq_stall(rq_stall), .mc_rs_vld(rs_vld), .mc_rs_cmd(rs_cmd),
    .mc_rs_scmd(rs_scmd), .mc_rs_data(rs_data), .mc_rs_rtnctl(rs_rtnctl), .mc_rs_stall(rs_stall),
    .mc_rs_flush_cmplt(flush_cmplt), .err_unsup(err_unsup), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  scmd;
    logic [31:0] tag;
    logic [63:0] data;
    int          ready;
    int          seq;
  } rsp_t;

  rsp_t         q[$];
  logic [63:0]  mmem [1024];
  int           cyc = 0, next_seq = 0, shown = -1, target = -1;
  bit           pend = 0, m_unsup = 0, m_ovf = 0;
  logic [107:0] exp_bus = '0;
  int           total = 0, passed = 0;

  task automatic model_reset();
    q.delete();
    pend = 0; m_unsup = 0; m_ovf = 0;
    shown = next_seq - 1;
    exp_bus = '0;
  endtask

  // Called at the active edge: consumes the inputs of the cycle that just ended, predicts the next cycle.
  task automatic model_edge();
    rsp_t e, h;
    bit full;
    logic e_vld, e_pulse;
    logic [102:0] e_fields;
    e_vld = 0; e_pulse = 0; e_fields = '0;
    if (!rst_n) begin model_reset(); return; end
    full = (q.size() == DEPTH);
    if (rq_vld) begin
      if (rq_cmd == 3'd1 || rq_cmd == 3'd2) begin
        if (rq_cmd == 3'd2) mmem[rq_vadr[12:3]] = rq_data;
        if (full) m_ovf = 1;
        else begin
          e.wr = (rq_cmd == 3'd2); e.scmd = rq_scmd; e.tag = rq_rtnctl;
          e.data = e.wr ? 64'd0 : mmem[rq_vadr[12:3]];
          e.ready = cyc + LAT - 1; e.seq = next_seq;
          next_seq++;
          q.push_back(e);
        end
      end else m_unsup = 1;
    end
    if (rq_flush) begin pend = 1; target = next_seq - 1; end
    if (pend && target <= shown) begin e_pulse = 1; pend = 0; end
    if (!rs_stall && q.size() > 0 && q[0].ready <= cyc) begin
      h = q.pop_front();
      shown = h.seq; e_vld = 1;
      e_fields = {h.wr ? 3'd3 : 3'd2, h.scmd, h.tag, h.data};
    end
    exp_bus = {e_vld, e_fields, q.size() >= DEPTH - 2, e_pulse, m_unsup, m_ovf};
  endtask

  function automatic logic [107:0] obs();
    return {rs_vld, rs_vld ? {rs_cmd, rs_scmd, rs_rtnctl, rs_data} : 103'd0, rq_stall, flush_cmplt, err_unsup, err_ovf};
  endfunction

  function automatic logic [47:0] rand_vadr(input int i);
    logic [47:0] v;
    v = {16'($urandom), $urandom};
    v[12:3] = 10'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic v, input logic [2:0] c, input logic [3:0] s, input logic [47:0] a,
                         input logic [31:0] t, input logic [63:0] d);
    rq_vld = v; rq_cmd = c; rq_scmd = s; rq_vadr = a; rq_rtnctl = t; rq_data = d; rq_size = 2'($urandom);
  endtask

  task automatic test_reset();
    logic [142:0] raw;
    rst_n = 0; model_reset();
    repeat (2) tick();
    raw = {rq_stall, rs_vld, rs_cmd, rs_scmd, rs_data, rs_rtnctl, flush_cmplt, err_unsup, err_ovf};
    total++; if (raw !== '0) $display("FAIL reset_outputs got=%h exp=0", raw); else passed++;
    #2 rst_n = 1;
  endtask

  task automatic test_init_mem();
    for (int i = 0; i < 24; i++) begin
      if (i < 16) set_req(1, 3'd2, 4'($urandom), rand_vadr(i), 32'hA000 + i, {$urandom, $urandom});
      else set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL init_mem cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
    end
  endtask

  task automatic test_write_read();
    set_req(1, 3'd2, 4'h1, 48'h40, 32'h11, 64'hDEAD_BEEF);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) set_req(1, 3'd1, 4'h2, 48'h40, 32'h12, 64'd0);
      else set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      total++; if (obs() !== exp_bus) $display("FAIL wr_rd_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (k == 4) begin
        total++;
        if (!(rs_vld === 1'b1 && rs_cmd === 3'd3 && rs_rtnctl === 32'h11))
          $display("FAIL wr_cmplt_t4 got vld=%b cmd=%0d tag=%h exp vld=1 cmd=3 tag=11", rs_vld, rs_cmd, rs_rtnctl);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if (!(rs_vld === 1'b1 && rs_cmd === 3'd2 && rs_data === 64'hDEAD_BEEF && rs_rtnctl === 32'h12))
          $display("FAIL rd_data_t5 got vld=%b cmd=%0d data=%h tag=%h exp vld=1 cmd=2 data=deadbeef tag=12", rs_vld, rs_cmd, rs_data, rs_rtnctl);
        else passed++;
      end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    rs_stall = 1;
    for (int i = 0; i < 20; i++) begin
      set_req(1, 3'd1, 4'h3, rand_vadr(i % 16), 32'd100 + i, 64'd0);
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL ovf_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      total++;
      if (rq_stall !== (i >= 13) || err_ovf !== (i >= 16))
        $display("FAIL ovf_flags read=%0d got stall=%b ovf=%b exp stall=%b ovf=%b", i, rq_stall, err_ovf, i >= 13, i >= 16);
      else passed++;
    end
    set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
    rs_stall = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (rs_vld) begin
        total++; if (rs_rtnctl !== 32'd100 + n) $display("FAIL ovf_order got=%0d exp=%0d", rs_rtnctl, 100 + n); else passed++;
        n++;
      end
    end
    total++; if (n != 16) $display("FAIL ovf_count got=%0d exp=16", n); else passed++;
  endtask

  task automatic test_stall_toggle();
    int n = 0;
    logic prev;
    for (int c = 0; c < 40; c++) begin
      rs_stall = c[0];
      if (c < 10) set_req(1, 3'd1, 4'h7, rand_vadr(c), 32'd200 + c, 64'd0);
      else set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      prev = rs_stall;
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL toggle_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (rs_vld) begin
        total++;
        if (prev || rs_rtnctl !== 32'd200 + n)
          $display("FAIL toggle_issue cyc=%0d got tag=%0d after_stall=%b exp tag=%0d after_stall=0", cyc, rs_rtnctl, prev, 200 + n);
        else passed++;
        n++;
      end
    end
    rs_stall = 0;
    total++; if (n != 10) $display("FAIL toggle_count got=%0d exp=10", n); else passed++;
  endtask

  task automatic test_flush();
    int pulses = 0, pc = -1, wc3 = -100;
    for (int k = 0; k < 16; k++) begin
      if (k < 3) set_req(1, 3'd2, 4'h9, rand_vadr(k), 32'h300 + k, {$urandom, $urandom});
      else set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      rq_flush = (k == 3);
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL flush_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (rs_vld && rs_rtnctl === 32'h302) wc3 = cyc;
      if (flush_cmplt) begin pulses++; pc = cyc; end
    end
    rq_flush = 0;
    total++;
    if (pulses != 1 || pc != wc3 + 1) $display("FAIL flush_pulse got count=%0d at=%0d exp count=1 at=%0d", pulses, pc, wc3 + 1);
    else passed++;
    rq_flush = 1;
    tick();
    rq_flush = 0;
    total++; if (flush_cmplt !== 1'b1 || obs() !== exp_bus) $display("FAIL idle_flush got=%b exp=1", flush_cmplt); else passed++;
    tick();
    total++; if (flush_cmplt !== 1'b0 || obs() !== exp_bus) $display("FAIL idle_flush_end got=%b exp=0", flush_cmplt); else passed++;
  endtask

  task automatic test_unsup_reset();
    int n = 0;
    logic [142:0] raw;
    total++; if (err_unsup !== 1'b0) $display("FAIL unsup_pre got=%b exp=0", err_unsup); else passed++;
    set_req(1, 3'd5, 4'h1, rand_vadr(3), 32'h0BAD, 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      total++; if (obs() !== exp_bus) $display("FAIL unsup_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (rs_vld) n++;
    end
    total++; if (err_unsup !== 1'b1 || n != 0) $display("FAIL unsup got err=%b rsps=%0d exp err=1 rsps=0", err_unsup, n); else passed++;
    for (int i = 0; i < 5; i++) begin
      set_req(1, 3'd1, 4'h4, rand_vadr(i), 32'd400 + i, 64'd0);
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL burst_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
    end
    rst_n = 0; model_reset();
    #1;
    raw = {rq_stall, rs_vld, rs_cmd, rs_scmd, rs_data, rs_rtnctl, flush_cmplt, err_unsup, err_ovf};
    total++; if (raw !== '0) $display("FAIL midreset_outputs got=%h exp=0", raw); else passed++;
    set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
    repeat (2) tick();
    rst_n = 1;
    set_req(1, 3'd1, 4'h6, rand_vadr(8), 32'h4FF, 64'd0);
    n = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      total++; if (obs() !== exp_bus) $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
      if (rs_vld) begin
        n++;
        total++;
        if (rs_rtnctl !== 32'h4FF || rs_data !== 64'hDEAD_BEEF)
          $display("FAIL stale_rsp got tag=%h data=%h exp tag=4ff data=deadbeef", rs_rtnctl, rs_data);
        else passed++;
      end
    end
    total++; if (n != 1) $display("FAIL post_reset_count got=%0d exp=1", n); else passed++;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      rs_stall = ($urandom % 4 == 0);
      rq_flush = ($urandom % 20 == 0);
      r = $urandom % 16;
      if ($urandom % 3 == 0) set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
      else if (r < 7) set_req(1, 3'd1, 4'($urandom), rand_vadr($urandom % 16), $urandom, 64'd0);
      else if (r < 14) set_req(1, 3'd2, 4'($urandom), rand_vadr($urandom % 16), $urandom, {$urandom, $urandom});
      else set_req(1, (r == 14) ? 3'd0 : 3'd6, 4'($urandom), rand_vadr(1), $urandom, 64'd0);
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
    end
    rs_stall = 0; rq_flush = 0;
    set_req(0, 3'd0, 4'd0, 48'd0, 32'd0, 64'd0);
    for (int c = 0; c < 40; c++) begin
      tick();
      total++; if (obs() !== exp_bus) $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_bus); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_init_mem();
    test_write_read();
    test_overflow();
    test_stall_toggle();
    test_flush();
    test_unsup_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
